// File: rtl/image_window_crop_pkg.sv
// Shared types and widths for the image window crop block.
// Holds the control state encoding, the window field widths, the default
// pixel width and a saturating increment used by the row/column counters.
package image_window_crop_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        IN_FRAME = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    localparam int X_W           = 11;
    localparam int Y_W           = 12;
    localparam int WIDTH_W       = 12;
    localparam int HEIGHT_W      = 11;
    localparam int CNT_W         = 13;
    localparam int PIX_W_DEFAULT = 12;

    // Counters stick at all-ones instead of wrapping back into the window.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/image_window_crop_sync_fifo.sv
// Single-clock FIFO with registered read data.
// Ports: clk/srst (sync active-high), wr_en/wr_data/full, rd_en/rd_data/empty.
// rd_data always presents the entry at the head; it is updated at the same
// edge that changes the head, so it is valid whenever empty is low.
// Writes while full and reads while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             do_wr;
    logic             do_rd;

    always_comb begin
        full     = (count_q == (AW+1)'(DEPTH));
        empty    = (count_q == '0);
        do_wr    = wr_en && !full;
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        count_d  = count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        // The new head is the entry being written this cycle when the FIFO
        // is (or becomes) empty; the memory still holds stale data there.
        if (do_wr && (wr_ptr_q == rd_ptr_d)) begin
            rd_data_d = wr_data;
        end else begin
            rd_data_d = mem[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/image_window_crop.sv
// Readout-window crop between the camera capture path and the JPEG block.
// Inputs: cfg_valid + window/metadata fields, pixel stream (pix_valid,
// pix_data, fv, lv), out_ready. Outputs: FIFO head pixel with valid/ready,
// per-frame metadata with a start-of-frame pulse, frame_done pulse and
// sticky overflow / short-frame flags.
module image_window_crop
    import image_window_crop_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int PIX_W      = PIX_W_DEFAULT
) (
    input  logic                sysClk,
    input  logic                hard_reset,
    input  logic                cfg_valid,
    input  logic [X_W-1:0]      upper_left_x_val,
    input  logic [Y_W-1:0]      upper_left_y_val,
    input  logic [WIDTH_W-1:0]  img_width,
    input  logic [HEIGHT_W-1:0] img_height,
    input  logic [27:0]         timestamp,
    input  logic [15:0]         trigger_index,
    input  logic                cam_id,
    input  logic                pix_valid,
    input  logic [PIX_W-1:0]    pix_data,
    input  logic                fv,
    input  logic                lv,
    input  logic                out_ready,
    output logic [PIX_W-1:0]    image_pixel_data,
    output logic                image_data_valid,
    output logic                image_metadata_valid,
    output logic [27:0]         meta_timestamp,
    output logic [15:0]         meta_trigger_index,
    output logic                meta_cam_id,
    output logic                frame_done,
    output logic                crop_overflow_flag,
    output logic                frame_short_flag
);

    state_t              state_q, state_d;
    logic                fv_prev_q, fv_prev_d;
    logic                lv_prev_q, lv_prev_d;
    logic [CNT_W-1:0]    col_q, col_d;
    logic [CNT_W-1:0]    row_q, row_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [WIDTH_W-1:0]  w_q, w_d;
    logic [HEIGHT_W-1:0] h_q, h_d;
    logic [27:0]         ts_q, ts_d;
    logic [15:0]         trig_q, trig_d;
    logic                cam_q, cam_d;
    logic                ovf_q, ovf_d;
    logic                short_q, short_d;

    logic             fv_rise, fv_fall, lv_fall, pix_take, in_win;
    logic [CNT_W-1:0] x_end, y_end, rows_done;
    logic             fifo_wr, fifo_full, fifo_empty, fifo_rd;
    logic             meta_pulse, done_pulse;

    always_comb begin
        fv_rise  = fv && !fv_prev_q;
        fv_fall  = !fv && fv_prev_q;
        lv_fall  = !lv && lv_prev_q;
        pix_take = pix_valid && lv;
        // 13-bit window ends cannot wrap for any legal field values.
        x_end    = {2'b00, x_q} + {1'b0, w_q};
        y_end    = {1'b0, y_q} + {2'b00, h_q};
        in_win   = (col_q >= {2'b00, x_q}) && (col_q < x_end) &&
                   (row_q >= {1'b0, y_q}) && (row_q < y_end);
        fifo_wr  = (state_q == IN_FRAME) && pix_take && in_win;
        fifo_rd  = !fifo_empty && out_ready;
        // A line ending in the same cycle as the frame still counts as done.
        rows_done = lv_fall ? sat_inc(row_q) : row_q;

        state_d    = state_q;
        fv_prev_d  = fv;
        lv_prev_d  = lv;
        col_d      = col_q;
        row_d      = row_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        ts_d       = ts_q;
        trig_d     = trig_q;
        cam_d      = cam_q;
        ovf_d      = ovf_q;
        short_d    = short_q;
        meta_pulse = 1'b0;
        done_pulse = 1'b0;

        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    x_d     = upper_left_x_val;
                    y_d     = upper_left_y_val;
                    w_d     = img_width;
                    h_d     = img_height;
                    ts_d    = timestamp;
                    trig_d  = trigger_index;
                    cam_d   = cam_id;
                    state_d = ARMED;
                end
            end
            ARMED: begin
                // Only a true rising edge starts a frame, so a frame already
                // in progress when we were armed is skipped entirely.
                if (fv_rise) begin
                    meta_pulse = 1'b1;
                    row_d      = '0;
                    col_d      = '0;
                    ovf_d      = 1'b0;
                    short_d    = 1'b0;
                    state_d    = IN_FRAME;
                end
            end
            IN_FRAME: begin
                if (pix_take) begin
                    col_d = sat_inc(col_q);
                end
                if (lv_fall) begin
                    col_d = '0;
                    row_d = sat_inc(row_q);
                end
                if (fifo_wr && fifo_full) begin
                    ovf_d = 1'b1;
                end
                if (fv_fall) begin
                    if (rows_done < y_end) begin
                        short_d = 1'b1;
                    end
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    done_pulse = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysClk) begin
        if (hard_reset) begin
            state_q   <= IDLE;
            fv_prev_q <= 1'b0;
            lv_prev_q <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            w_q       <= '0;
            h_q       <= '0;
            ts_q      <= '0;
            trig_q    <= '0;
            cam_q     <= 1'b0;
            ovf_q     <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            fv_prev_q <= fv_prev_d;
            lv_prev_q <= lv_prev_d;
            col_q     <= col_d;
            row_q     <= row_d;
            x_q       <= x_d;
            y_q       <= y_d;
            w_q       <= w_d;
            h_q       <= h_d;
            ts_q      <= ts_d;
            trig_q    <= trig_d;
            cam_q     <= cam_d;
            ovf_q     <= ovf_d;
            short_q   <= short_d;
        end
    end

    sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sysClk),
        .srst    (hard_reset),
        .wr_en   (fifo_wr),
        .wr_data (pix_data),
        .full    (fifo_full),
        .rd_en   (fifo_rd),
        .rd_data (image_pixel_data),
        .empty   (fifo_empty)
    );

    // Pulses are masked while reset is held so a flush never looks like a
    // completed frame.
    assign image_data_valid     = !fifo_empty;
    assign image_metadata_valid = meta_pulse && !hard_reset;
    assign frame_done           = done_pulse && !hard_reset;
    assign meta_timestamp       = ts_q;
    assign meta_trigger_index   = trig_q;
    assign meta_cam_id          = cam_q;
    assign crop_overflow_flag   = ovf_q;
    assign frame_short_flag     = short_q;

endmodule

// File: tb/tb_image_window_crop.sv
// Self-checking bench for image_window_crop. The reference model decides
// which pixels belong to the window from the frame's row/column indices and
// collects them in an expected queue; everything popped from the DUT goes
// into a received queue and the two are compared per scenario.
module tb_image_window_crop;

    localparam int DEPTH = 4;
    localparam int PW    = 12;

    logic          sysClk = 1'b0;
    logic          hard_reset;
    logic          cfg_valid;
    logic [10:0]   upper_left_x_val;
    logic [11:0]   upper_left_y_val;
    logic [11:0]   img_width;
    logic [10:0]   img_height;
    logic [27:0]   timestamp;
    logic [15:0]   trigger_index;
    logic          cam_id;
    logic          pix_valid;
    logic [PW-1:0] pix_data;
    logic          fv;
    logic          lv;
    logic          out_ready;
    logic [PW-1:0] image_pixel_data;
    logic          image_data_valid;
    logic          image_metadata_valid;
    logic [27:0]   meta_timestamp;
    logic [15:0]   meta_trigger_index;
    logic          meta_cam_id;
    logic          frame_done;
    logic          crop_overflow_flag;
    logic          frame_short_flag;

    image_window_crop #(.FIFO_DEPTH(DEPTH), .PIX_W(PW)) dut (
        .sysClk               (sysClk),
        .hard_reset           (hard_reset),
        .cfg_valid            (cfg_valid),
        .upper_left_x_val     (upper_left_x_val),
        .upper_left_y_val     (upper_left_y_val),
        .img_width            (img_width),
        .img_height           (img_height),
        .timestamp            (timestamp),
        .trigger_index        (trigger_index),
        .cam_id               (cam_id),
        .pix_valid            (pix_valid),
        .pix_data             (pix_data),
        .fv                   (fv),
        .lv                   (lv),
        .out_ready            (out_ready),
        .image_pixel_data     (image_pixel_data),
        .image_data_valid     (image_data_valid),
        .image_metadata_valid (image_metadata_valid),
        .meta_timestamp       (meta_timestamp),
        .meta_trigger_index   (meta_trigger_index),
        .meta_cam_id          (meta_cam_id),
        .frame_done           (frame_done),
        .crop_overflow_flag   (crop_overflow_flag),
        .frame_short_flag     (frame_short_flag)
    );

    always #5 sysClk = ~sysClk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int meta_cnt = 0;
    int done_cnt = 0;
    int hold_err = 0;
    int stall_seen = 0;
    bit prev_stall = 1'b0;
    logic [PW-1:0] prev_data;
    logic [PW-1:0] got[$];
    logic [PW-1:0] exp_q[$];
    int ready_mode = 0;
    bit ready_const = 1'b1;
    int m_x, m_y, m_w, m_h;

    // One clock cycle: choose out_ready, sample outputs before the edge,
    // record pops/pulses, then advance to just after the next edge.
    task automatic step();
        if (ready_mode == 1) out_ready = (cyc % 4 == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        else                 out_ready = ready_const;
        #1;
        if (image_data_valid && out_ready) got.push_back(image_pixel_data);
        if (image_metadata_valid) meta_cnt++;
        if (frame_done) done_cnt++;
        if (hard_reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!image_data_valid || image_pixel_data !== prev_data)) hold_err++;
            prev_stall = image_data_valid && !out_ready;
            if (prev_stall) stall_seen++;
        end
        prev_data = image_pixel_data;
        @(posedge sysClk);
        #1;
        cyc++;
    endtask

    task automatic do_cfg(input int x, input int y, input int w, input int h,
                          input logic [27:0] ts, input logic [15:0] ti, input logic id);
        upper_left_x_val = 11'(x);
        upper_left_y_val = 12'(y);
        img_width        = 12'(w);
        img_height       = 11'(h);
        timestamp        = ts;
        trigger_index    = ti;
        cam_id           = id;
        cfg_valid        = 1'b1;
        step();
        cfg_valid = 1'b0;
        m_x = x; m_y = y; m_w = w; m_h = h;
        $display("cfg x=%0d y=%0d w=%0d h=%0d ts=%07h", x, y, w, h, ts);
    endtask

    function automatic bit in_win(input int r, input int c);
        return (c >= m_x) && (c < m_x + m_w) && (r >= m_y) && (r < m_y + m_h);
    endfunction

    task automatic drive_frame(input int nlines, input int npix, input bit use_rc,
                               input bit sparse, input bit rnd_gap);
        fv = 1'b1;
        step();
        step();
        for (int r = 0; r < nlines; r++) begin
            lv = 1'b1;
            for (int c = 0; c < npix; c++) begin
                if (sparse) begin
                    while (cyc % 4 != 0) begin pix_valid = 1'b0; step(); end
                end
                if (rnd_gap) begin
                    while ($urandom_range(0, 2) == 0) begin pix_valid = 1'b0; step(); end
                end
                pix_valid = 1'b1;
                pix_data  = use_rc ? 12'(r * 16 + c) : 12'($urandom);
                if (in_win(r, c)) exp_q.push_back(pix_data);
                step();
            end
            pix_valid = 1'b0;
            lv = 1'b0;
            step();
            step();
        end
        fv = 1'b0;
        step();
        $display("frame lines=%0d px=%0d expected_pixels=%0d", nlines, npix, exp_q.size());
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            step();
            if (done_cnt != d0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        hard_reset = 1'b1; cfg_valid = 1'b0; pix_valid = 1'b0; pix_data = '0;
        fv = 1'b0; lv = 1'b0; ready_const = 1'b1;
        upper_left_x_val = '0; upper_left_y_val = '0; img_width = '0; img_height = '0;
        timestamp = '0; trigger_index = '0; cam_id = 1'b0;
        step(); step();
        hard_reset = 1'b0;
        total++; if (image_data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", image_data_valid); end
        total++; if (image_pixel_data !== 12'h000) begin bad++; $display("FAIL reset_data got=%h want=000", image_pixel_data); end
        total++; if (image_metadata_valid !== 1'b0 || frame_done !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b want=00", image_metadata_valid, frame_done); end
        total++; if (crop_overflow_flag !== 1'b0 || frame_short_flag !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", crop_overflow_flag, frame_short_flag); end
        total++; if (meta_timestamp !== 28'h0 || meta_trigger_index !== 16'h0 || meta_cam_id !== 1'b0) begin bad++; $display("FAIL reset_meta got=%h/%h/%b want=0", meta_timestamp, meta_trigger_index, meta_cam_id); end
        step();
    endtask

    task automatic test_basic();
        logic [PW-1:0] tbl [6] = '{12'h012, 12'h013, 12'h014, 12'h022, 12'h023, 12'h024};
        int m0, d0; bit ok;
        got.delete(); exp_q.delete(); ready_mode = 0; ready_const = 1'b1;
        m0 = meta_cnt; d0 = done_cnt;
        do_cfg(2, 1, 3, 2, 28'h1234567, 16'hBEEF, 1'b1);
        drive_frame(4, 6, 1'b1, 1'b0, 1'b0);
        wait_done(d0, ok);
        repeat (3) step();
        total++; if (!ok) begin bad++; $display("FAIL basic_done_timeout got=none want=frame_done"); end
        total++; if (got.size() != 6) begin bad++; $display("FAIL basic_count got=%0d want=6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            total++; if (got[i] !== tbl[i]) begin bad++; $display("FAIL basic_pix[%0d] got=%h want=%h", i, got[i], tbl[i]); end
        end
        total++; if (meta_cnt - m0 != 1) begin bad++; $display("FAIL basic_meta_pulses got=%0d want=1", meta_cnt - m0); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d want=1", done_cnt - d0); end
        total++; if (crop_overflow_flag !== 1'b0 || frame_short_flag !== 1'b0) begin bad++; $display("FAIL basic_flags got=%b%b want=00", crop_overflow_flag, frame_short_flag); end
        total++; if (meta_timestamp !== 28'h1234567 || meta_trigger_index !== 16'hBEEF || meta_cam_id !== 1'b1) begin bad++; $display("FAIL basic_meta got=%h/%h/%b want=1234567/beef/1", meta_timestamp, meta_trigger_index, meta_cam_id); end
    endtask

    task automatic test_short();
        logic [PW-1:0] tbl [3] = '{12'h012, 12'h013, 12'h014};
        int d0; bit ok;
        got.delete(); exp_q.delete();
        d0 = done_cnt;
        do_cfg(2, 1, 3, 2, 28'h0000042, 16'h0002, 1'b0);
        drive_frame(2, 6, 1'b1, 1'b0, 1'b0);
        wait_done(d0, ok);
        total++; if (!ok) begin bad++; $display("FAIL short_done_timeout got=none want=frame_done"); end
        total++; if (got.size() != 3) begin bad++; $display("FAIL short_count got=%0d want=3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            total++; if (got[i] !== tbl[i]) begin bad++; $display("FAIL short_pix[%0d] got=%h want=%h", i, got[i], tbl[i]); end
        end
        total++; if (frame_short_flag !== 1'b1) begin bad++; $display("FAIL short_flag got=%b want=1", frame_short_flag); end
        total++; if (crop_overflow_flag !== 1'b0) begin bad++; $display("FAIL short_ovf got=%b want=0", crop_overflow_flag); end
    endtask

    task automatic test_overflow();
        int d0; bit ok;
        got.delete(); exp_q.delete(); ready_const = 1'b0;
        d0 = done_cnt;
        do_cfg(0, 0, 8, 1, 28'h0000777, 16'h0003, 1'b0);
        drive_frame(1, 8, 1'b1, 1'b0, 1'b0);
        repeat (5) step();
        total++; if (crop_overflow_flag !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b want=1", crop_overflow_flag); end
        total++; if (got.size() != 0 || image_data_valid !== 1'b1) begin bad++; $display("FAIL ovf_stalled got=%0d/%b want=0/1", got.size(), image_data_valid); end
        total++; if (done_cnt != d0) begin bad++; $display("FAIL ovf_early_done got=%0d want=0", done_cnt - d0); end
        ready_const = 1'b1;
        wait_done(d0, ok);
        total++; if (!ok) begin bad++; $display("FAIL ovf_done_timeout got=none want=frame_done"); end
        total++; if (got.size() != DEPTH) begin bad++; $display("FAIL ovf_count got=%0d want=%0d", got.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < got.size(); i++) begin
            total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL ovf_pix[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
        end
        total++; if (image_data_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained got=%b want=0", image_data_valid); end
    endtask

    task automatic test_stall();
        int d0, h0; bit ok;
        got.delete(); exp_q.delete();
        d0 = done_cnt; h0 = stall_seen;
        do_cfg(1, 1, 4, 3, 28'h0000123, 16'h0004, 1'b1);
        ready_mode = 1;
        drive_frame(5, 7, 1'b0, 1'b1, 1'b0);
        wait_done(d0, ok);
        ready_mode = 0; ready_const = 1'b1;
        total++; if (!ok) begin bad++; $display("FAIL stall_done_timeout got=none want=frame_done"); end
        total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL stall_count got=%0d want=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL stall_pix[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
        end
        total++; if (hold_err != 0) begin bad++; $display("FAIL stall_hold got=%0d want=0", hold_err); end
        total++; if (stall_seen == h0) begin bad++; $display("FAIL stall_exercised got=0 want=>0"); end
        total++; if (crop_overflow_flag !== 1'b0) begin bad++; $display("FAIL stall_ovf got=%b want=0", crop_overflow_flag); end
    endtask

    task automatic test_partial();
        int m0, d0; bit ok;
        got.delete(); exp_q.delete();
        m0 = meta_cnt; d0 = done_cnt;
        fv = 1'b1;
        repeat (3) step();
        do_cfg(1, 0, 2, 1, 28'h0ABCDEF, 16'h0005, 1'b0);
        lv = 1'b1;
        for (int c = 0; c < 4; c++) begin pix_valid = 1'b1; pix_data = 12'(c); step(); end
        pix_valid = 1'b0; lv = 1'b0; step();
        fv = 1'b0; step(); step();
        drive_frame(2, 4, 1'b1, 1'b0, 1'b0);
        wait_done(d0, ok);
        total++; if (!ok) begin bad++; $display("FAIL partial_done_timeout got=none want=frame_done"); end
        total++; if (meta_timestamp !== 28'h0ABCDEF) begin bad++; $display("FAIL partial_ts got=%h want=0abcdef", meta_timestamp); end
        total++; if (meta_cnt - m0 != 1) begin bad++; $display("FAIL partial_meta_pulses got=%0d want=1", meta_cnt - m0); end
        total++; if (done_cnt - d0 != 1) begin bad++; $display("FAIL partial_done_pulses got=%0d want=1", done_cnt - d0); end
        total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL partial_count got=%0d want=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL partial_pix[%0d] got=%h want=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_zero_window();
        int d0; bit ok;
        got.delete(); exp_q.delete();
        d0 = done_cnt;
        do_cfg(0, 0, 0, 3, 28'h0000009, 16'h0006, 1'b0);
        drive_frame(3, 4, 1'b1, 1'b0, 1'b0);
        wait_done(d0, ok);
        total++; if (!ok) begin bad++; $display("FAIL zero_done_timeout got=none want=frame_done"); end
        total++; if (got.size() != 0) begin bad++; $display("FAIL zero_count got=%0d want=0", got.size()); end
        total++; if (frame_short_flag !== 1'b0) begin bad++; $display("FAIL zero_short got=%b want=0", frame_short_flag); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int x, y, w, h, nl, np, d0; bit ok; bit exp_short;
            got.delete(); exp_q.delete();
            x = $urandom_range(0, 5); y = $urandom_range(0, 4);
            w = $urandom_range(0, 5); h = $urandom_range(0, 4);
            nl = $urandom_range(1, 6); np = $urandom_range(1, 8);
            exp_short = (nl < y + h);
            d0 = done_cnt;
            do_cfg(x, y, w, h, 28'($urandom), 16'($urandom), 1'($urandom));
            drive_frame(nl, np, 1'b0, 1'b0, 1'b1);
            wait_done(d0, ok);
            total++; if (!ok) begin bad++; $display("FAIL rnd%0d_done_timeout got=none want=frame_done", it); end
            total++; if (got.size() != exp_q.size()) begin bad++; $display("FAIL rnd%0d_count got=%0d want=%0d", it, got.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                total++; if (got[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_pix[%0d] got=%h want=%h", it, i, got[i], exp_q[i]); end
            end
            total++; if (frame_short_flag !== exp_short) begin bad++; $display("FAIL rnd%0d_short got=%b want=%b", it, frame_short_flag, exp_short); end
            total++; if (crop_overflow_flag !== 1'b0) begin bad++; $display("FAIL rnd%0d_ovf got=%b want=0", it, crop_overflow_flag); end
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        got.delete(); exp_q.delete(); ready_const = 1'b0;
        do_cfg(0, 0, 10, 2, 28'h0000111, 16'h0007, 1'b1);
        fv = 1'b1; step(); step();
        lv = 1'b1;
        for (int c = 0; c < 3; c++) begin pix_valid = 1'b1; pix_data = 12'(12'h100 + c); step(); end
        pix_valid = 1'b0; step();
        total++; if (image_data_valid !== 1'b1) begin bad++; $display("FAIL rstmid_prefill got=%b want=1", image_data_valid); end
        d0 = done_cnt;
        hard_reset = 1'b1; step();
        hard_reset = 1'b0; lv = 1'b0; fv = 1'b0; ready_const = 1'b1;
        total++; if (image_data_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", image_data_valid); end
        total++; if (crop_overflow_flag !== 1'b0 || frame_short_flag !== 1'b0) begin bad++; $display("FAIL rstmid_flags got=%b%b want=00", crop_overflow_flag, frame_short_flag); end
        total++; if (meta_timestamp !== 28'h0) begin bad++; $display("FAIL rstmid_meta got=%h want=0", meta_timestamp); end
        repeat (20) step();
        total++; if (done_cnt != d0 || got.size() != 0) begin bad++; $display("FAIL rstmid_quiet got=%0d/%0d want=0/0", done_cnt - d0, got.size()); end
        do_cfg(0, 0, 1, 1, 28'h7654321, 16'h0008, 1'b0);
        step();
        total++; if (meta_timestamp !== 28'h7654321) begin bad++; $display("FAIL rstmid_idle_cfg got=%h want=7654321", meta_timestamp); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_overflow();
        test_stall();
        test_partial();
        test_zero_window();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
